// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } ctrlState_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline stage inputs and hazard control outputs
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegWriteAdd;
    logic [4:0]       IF_ID_RegAdd1;
    logic [4:0]       IF_ID_RegAdd2;
    logic             IF_ID_UsesRt;
    logic             MD_Start;
    logic             Branch_Taken;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Mux;
    logic             MD_Go;
    logic             MD_Busy;
    logic [CNT_W-1:0] Stall_Count;

    // Pipeline side: drives stage information, observes controls.
    modport master (
        output ID_EX_MemRead, ID_EX_RegWriteAdd, IF_ID_RegAdd1, IF_ID_RegAdd2,
               IF_ID_UsesRt, MD_Start, Branch_Taken,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Mux, MD_Go, MD_Busy,
               Stall_Count
    );

    // Controller side.
    modport slave (
        input  ID_EX_MemRead, ID_EX_RegWriteAdd, IF_ID_RegAdd1, IF_ID_RegAdd2,
               IF_ID_UsesRt, MD_Start, Branch_Taken,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Mux, MD_Go, MD_Busy,
               Stall_Count
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - load-use hazard detection between EX and ID
module hazard_detect_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       memRead,
    input  logic [4:0] exDest,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       usesRt,
    output logic       loadUse
);
    // A load into $0 never creates a dependency; rt only matters if ID reads it.
    always_comb begin
        loadUse = memRead && (exDest != REG_ZERO) &&
                  ((exDest == idRs) || (usesRt && (exDest == idRt)));
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for PC, IF/ID and ID/EX
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
)(
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 1);

    ctrlState_t       state, nextState;
    logic [7:0]       mdCnt, nextMdCnt;
    logic [CNT_W-1:0] stallCnt;
    logic             loadUse;
    logic             pcWrite, ifIdWrite, ifIdFlush, idExMux, mdGo;

    hazard_detect_unit u_hdu (
        .memRead (hz.ID_EX_MemRead),
        .exDest  (hz.ID_EX_RegWriteAdd),
        .idRs    (hz.IF_ID_RegAdd1),
        .idRt    (hz.IF_ID_RegAdd2),
        .usesRt  (hz.IF_ID_UsesRt),
        .loadUse (loadUse)
    );

    // Next state and hazard controls; branch beats load-use beats mult/div.
    always_comb begin
        nextState = state;
        nextMdCnt = mdCnt;
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b0;
        idExMux   = 1'b0;
        mdGo      = 1'b0;
        if (rst) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExMux   = 1'b1;
            nextState = RUN;
            nextMdCnt = 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.Branch_Taken) begin
                        ifIdFlush = 1'b1;
                        idExMux   = 1'b1;
                    end else if (loadUse) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        idExMux   = 1'b1;
                    end else if (hz.MD_Start) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        idExMux   = 1'b1;
                        mdGo      = 1'b1;
                        nextMdCnt = MD_INIT;
                        nextState = MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    if (hz.Branch_Taken) begin
                        // The mult/div was on the wrong path; its result is dropped downstream.
                        ifIdFlush = 1'b1;
                        idExMux   = 1'b1;
                        nextMdCnt = 8'd0;
                        nextState = RUN;
                    end else if (mdCnt != 8'd0) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        idExMux   = 1'b1;
                        nextMdCnt = mdCnt - 8'd1;
                    end else begin
                        // Release; MD_Start still asserted here is the same op, not a new one.
                        nextState = RUN;
                    end
                end
                default: nextState = RUN;
            endcase
        end
    end

    // State and mult/div countdown registers.
    always_ff @(posedge clk) begin
        state <= nextState;
        mdCnt <= nextMdCnt;
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (!pcWrite && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign hz.PC_Write    = pcWrite;
    assign hz.IF_ID_Write = ifIdWrite;
    assign hz.IF_ID_Flush = ifIdFlush;
    assign hz.ID_EX_Mux   = idExMux;
    assign hz.MD_Go       = mdGo;
    assign hz.MD_Busy     = (state == MD_WAIT) && !rst;
    assign hz.Stall_Count = stallCnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) a ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  b ();

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .hz(a));
    pipeline_hazard_ctrl #(.MD_LATENCY(1), .CNT_W(4))  dutB (.clk(clk), .rst(rst), .hz(b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Mux, MD_Go, MD_Busy}
    task automatic outA(input string tag, input logic [5:0] e);
        chk(tag, {26'd0, a.PC_Write, a.IF_ID_Write, a.IF_ID_Flush, a.ID_EX_Mux, a.MD_Go, a.MD_Busy},
            {26'd0, e});
    endtask

    task automatic outB(input string tag, input logic [5:0] e);
        chk(tag, {26'd0, b.PC_Write, b.IF_ID_Write, b.IF_ID_Flush, b.ID_EX_Mux, b.MD_Go, b.MD_Busy},
            {26'd0, e});
    endtask

    task automatic setA(input logic mr, input logic [4:0] dst, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur, input logic md, input logic br);
        a.ID_EX_MemRead = mr; a.ID_EX_RegWriteAdd = dst; a.IF_ID_RegAdd1 = rs;
        a.IF_ID_RegAdd2 = rt; a.IF_ID_UsesRt = ur; a.MD_Start = md; a.Branch_Taken = br;
        #1;
    endtask

    task automatic setB(input logic mr, input logic [4:0] dst, input logic [4:0] rs, input logic md);
        b.ID_EX_MemRead = mr; b.ID_EX_RegWriteAdd = dst; b.IF_ID_RegAdd1 = rs;
        b.IF_ID_RegAdd2 = 5'd0; b.IF_ID_UsesRt = 1'b0; b.MD_Start = md; b.Branch_Taken = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        setA(0, 0, 0, 0, 0, 0, 0);
        setB(0, 0, 0, 0);
        outA("reset_forced", 6'b000100);
        outB("reset_forced_b", 6'b000100);
        tick();
        chk("reset_count", {16'd0, a.Stall_Count}, 32'd0);
        rst = 1'b0;
        #1;
        outA("idle", 6'b110000);

        // Load r8 in EX, ID reads rs=r8: one bubble.
        setA(1, 5'd8, 5'd8, 5'd1, 0, 0, 0);
        outA("lu_rs", 6'b000100);
        tick();
        setA(0, 5'd0, 5'd8, 5'd1, 0, 0, 0);
        outA("lu_rs_after", 6'b110000);
        tick();
        // Load into r0 never stalls.
        setA(1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        outA("lu_r0", 6'b110000);
        tick();
        // rt match only counts when ID uses rt.
        setA(1, 5'd9, 5'd3, 5'd9, 0, 0, 0);
        outA("lu_rt_unused", 6'b110000);
        setA(1, 5'd9, 5'd3, 5'd9, 1, 0, 0);
        outA("lu_rt_used", 6'b000100);
        tick();
        setA(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk("count_after_lu", {16'd0, a.Stall_Count}, 32'd2);

        // Mult/div with latency 4: stalls T..T+3, release T+4.
        setA(0, 0, 0, 0, 0, 1, 0);
        outA("md_T", 6'b000110);
        tick();
        outA("md_T1", 6'b000101);
        tick();
        outA("md_T2", 6'b000101);
        tick();
        outA("md_T3", 6'b000101);
        tick();
        outA("md_release", 6'b110001);
        tick();
        setA(0, 0, 0, 0, 0, 0, 0);
        outA("md_done", 6'b110000);
        chk("count_after_md", {16'd0, a.Stall_Count}, 32'd6);

        // MD_Start with load-use: load bubble first, MD_Go one cycle later, then branch kill.
        setA(1, 5'd5, 5'd5, 5'd0, 0, 1, 0);
        outA("md_lu_T", 6'b000100);
        tick();
        setA(0, 5'd0, 5'd5, 5'd0, 0, 1, 0);
        outA("md_lu_T1", 6'b000110);
        tick();
        outA("md_lu_T2", 6'b000101);
        tick();
        setA(0, 5'd0, 5'd5, 5'd0, 0, 1, 1);
        outA("md_branch_T3", 6'b111101);
        tick();
        setA(0, 0, 0, 0, 0, 0, 0);
        outA("md_branch_T4", 6'b110000);
        chk("count_after_branch", {16'd0, a.Stall_Count}, 32'd9);

        // Branch beats load-use and MD_Start in RUN.
        setA(1, 5'd7, 5'd7, 5'd0, 0, 1, 1);
        outA("branch_prio", 6'b111100);
        tick();
        setA(0, 0, 0, 0, 0, 0, 0);
        outA("branch_prio_next", 6'b110000);

        // Reset during MD_WAIT.
        setA(0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        outA("pre_reset_wait", 6'b000101);
        rst = 1'b1;
        #1;
        outA("reset_in_wait", 6'b000100);
        tick();
        rst = 1'b0;
        setA(0, 0, 0, 0, 0, 0, 0);
        outA("after_reset", 6'b110000);
        chk("count_after_reset", {16'd0, a.Stall_Count}, 32'd0);

        // Latency 1: single stall, release next cycle.
        setB(0, 0, 0, 1);
        outB("lat1_T", 6'b000110);
        tick();
        outB("lat1_release", 6'b110001);
        tick();
        setB(0, 0, 0, 0);
        outB("lat1_done", 6'b110000);
        chk("lat1_count", {28'd0, b.Stall_Count}, 32'd1);

        // 2^CNT_W+5 stall cycles saturate the 4-bit counter.
        setB(1, 5'd4, 5'd4, 0);
        for (int i = 0; i < 21; i++) tick();
        chk("saturate", {28'd0, b.Stall_Count}, 32'd15);
        tick();
        chk("saturate_hold", {28'd0, b.Stall_Count}, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
